gshare_ckpt: RTL

Parametrised gshare direction predictor with speculative global history and checkpoint-based history recovery. It is the successor to the fixed-width gshare block and sits in the IF stage. The PC and the speculative history index a saturating-counter PHT in the same cycle. The index and a history checkpoint travel down the pipeline; at EX the branch resolves, trains the PHT and, on a mispredict, restores the history. A post-reset sweep FSM initialises the PHT one entry per cycle.

---
 rtl/gshare_ckpt.sv | 133 +++++++++++++
 1 files changed

// File: rtl/gshare_ckpt.sv
// rtl/gshare_ckpt.sv - gshare predictor with speculative history, checkpoint recovery and PHT init sweep
// Optional same-cycle update-to-prediction forwarding is enabled by defining GSHARE_FWD_EN.
module gshare_ckpt #(
    parameter int IDX_BITS  = 8,
    parameter int HIST_BITS = 8,
    parameter int CTR_BITS  = 2,
    parameter int PC_BITS   = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic                 ready,
    input  logic                 pred_req,
    input  logic [PC_BITS-1:0]   pred_pc,
    output logic                 pred_take,
    output logic [IDX_BITS-1:0]  pred_index,
    output logic [HIST_BITS-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [IDX_BITS-1:0]  upd_index,
    input  logic                 upd_take,
    input  logic                 upd_mispredict,
    input  logic [HIST_BITS-1:0] upd_ghr
);

    localparam int PHT_SIZE = 1 << IDX_BITS;
    localparam logic [IDX_BITS:0]   SWEEP_LAST = (IDX_BITS+1)'(PHT_SIZE - 1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK   = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX    = {CTR_BITS{1'b1}};

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t               state;
    state_t               state_next;
    logic                 run;
    logic [IDX_BITS:0]    sweep;
    logic [HIST_BITS-1:0] ghr_spec;
    logic [HIST_BITS-1:0] ghr_shift;
    logic [HIST_BITS-1:0] ghr_recover;
    logic [CTR_BITS-1:0]  pht [PHT_SIZE];
    logic [IDX_BITS-1:0]  raw_index;
    logic [CTR_BITS-1:0]  upd_ctr;
    logic [CTR_BITS-1:0]  upd_ctr_next;
    logic [CTR_BITS-1:0]  rd_ctr;
    logic                 unused_bits;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        run        = 1'b0;
        case (state)
            S_INIT: begin
                if (sweep == SWEEP_LAST) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                run = 1'b1;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    assign ready     = run;
    assign raw_index = pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_spec);
    assign upd_ctr   = pht[upd_index];

    // Saturating step of the counter being trained this cycle.
    always_comb begin
        upd_ctr_next = upd_ctr;
        if (upd_take) begin
            if (upd_ctr != CTR_MAX) begin
                upd_ctr_next = upd_ctr + CTR_BITS'(1);
            end
        end else if (upd_ctr != '0) begin
            upd_ctr_next = upd_ctr - CTR_BITS'(1);
        end
    end

`ifdef GSHARE_FWD_EN
    assign rd_ctr = (upd_valid && (upd_index == raw_index)) ? upd_ctr_next : pht[raw_index];
`else
    assign rd_ctr = pht[raw_index];
`endif

    assign pred_take  = run & rd_ctr[CTR_BITS-1];
    assign pred_index = run ? raw_index : '0;
    assign pred_ghr   = run ? ghr_spec : '0;

    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign ghr_shift   = pred_take;
            assign ghr_recover = upd_take;
        end else begin : g_histn
            assign ghr_shift   = {ghr_spec[HIST_BITS-2:0], pred_take};
            assign ghr_recover = {upd_ghr[HIST_BITS-2:0], upd_take};
        end
    endgenerate

    // A mispredict recovery wins over the shift: that cycle's fetch is flushed.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sweep    <= '0;
            ghr_spec <= '0;
        end else if (state == S_INIT) begin
            sweep <= sweep + (IDX_BITS+1)'(1);
        end else if (upd_valid && upd_mispredict) begin
            ghr_spec <= ghr_recover;
        end else if (pred_req) begin
            ghr_spec <= ghr_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state == S_INIT) begin
                pht[sweep[IDX_BITS-1:0]] <= CTR_WEAK;
            end else if (upd_valid) begin
                pht[upd_index] <= upd_ctr_next;
            end
        end
    end

    assign unused_bits = ^{pred_pc[PC_BITS-1:IDX_BITS+2], pred_pc[1:0], upd_ghr[HIST_BITS-1]};

endmodule
